// File: rtl/accelbrot_com_ram_reader.sv
// Streams cmd_len consecutive words (address wraps modulo 2^ADDR_WIDTH) out of a
// two-stage SDP RAM read port into a small credit-protected output FIFO.
module accelbrot_com_ram_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_rem;
  logic                  r_v1;
  logic                  r_v2;
  logic                  r_l1;
  logic                  r_l2;

  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic                  r_fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [OCC_W-1:0]      r_occ;

  logic [OCC_W:0]        w_fill;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_adv;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rem_one;

  // Every word already requested (still in a RAM stage) must have a FIFO slot
  // reserved, so the FIFO can never overflow regardless of out_ready.
  assign w_fill    = (OCC_W+1)'(r_occ) + (OCC_W+1)'(r_v1) + (OCC_W+1)'(r_v2);
  assign w_credit  = (w_fill <= (OCC_W+1)'(FIFO_DEPTH - 1));
  assign w_issue   = (r_state == S_ISSUE);
  assign w_adv     = w_credit && (w_issue || ((r_state == S_DRAIN) && (r_v1 || r_v2)));
  assign w_push    = w_adv && r_v2;
  assign w_pop     = out_valid && out_ready;
  assign w_rem_one = (r_rem == (ADDR_WIDTH+1)'(1));

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign ram_rd_en   = w_adv;
  assign ram_rd_addr = r_addr;
  assign out_valid   = (r_occ != OCC_W'(0));
  assign out_data    = r_fifo_data[r_rptr];
  assign out_last    = r_fifo_last[r_rptr] && out_valid;

  // Command FSM, address counter and remaining-word count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && (cmd_len != (ADDR_WIDTH+1)'(0))) begin
            r_addr  <= cmd_addr;
            r_rem   <= cmd_len;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_adv) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            r_rem  <= r_rem - (ADDR_WIDTH+1)'(1);
            if (w_rem_one) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && out_last) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid/last flags shadowing the two RAM read stages; they shift with ram_rd_en.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_l1 <= 1'b0;
      r_l2 <= 1'b0;
    end else if (w_adv) begin
      r_v1 <= w_issue;
      r_l1 <= w_issue && w_rem_one;
      r_v2 <= r_v1;
      r_l2 <= r_l1;
    end
  end

  // Output FIFO; push captures stage-2 data before the stages shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wptr] <= ram_rd_data;
        r_fifo_last[r_wptr] <= r_l2;
        r_wptr              <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: doc/accelbrot_com_ram_reader.md
ACCELBROT_COM_RAM_READER -- requirements
Module: accelbrot_com_ram_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the RAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning the RAM address width; DEPTH = 2^ADDR_WIDTH.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, fixed at 4, meaning the output buffer entries.
REQ-004 The block SHALL use one clock and an asynchronous active-low reset: clk (in, 1) is the single clock; rstn (in, 1) is the asynchronous active-low reset.
REQ-005 The block SHALL have the following command ports:
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_len  in  ADDR_WIDTH+1  word count, 0..2^(ADDR_WIDTH+1)-1
REQ-006 The block SHALL have the following RAM read-port ports, to the single-clock SDP RAM read side:
- ram_rd_en  out  1  advances both RAM read stages
- ram_rd_addr  out  ADDR_WIDTH  read address
- ram_rd_data  in  DATA_WIDTH  RAM data register
REQ-007 The block SHALL have the following output-stream ports:
- out_valid  out  1
- out_ready  in  1
- out_data  out  DATA_WIDTH
- out_last  out  1  final word of command
REQ-008 The block SHALL have busy (out, 1), high whenever the state is not IDLE.

Function
REQ-009 The RAM model SHALL be as follows: each cycle with ram_rd_en=1, the RAM captures ram_rd_addr into stage1 and loads stage2 with mem[stage1]; nothing moves when ram_rd_en=0.
REQ-010 The block SHALL track flags v1/v2 (stage holds a requested word) and l1/l2 (that word is last), updated only on ram_rd_en cycles.
REQ-011 The state machine SHALL have states IDLE, ISSUE and DRAIN.
REQ-012 In IDLE, cmd_ready SHALL be 1; in ISSUE and DRAIN, cmd_ready SHALL be 0.
REQ-013 On IDLE with cmd_valid and cmd_len=0, the block SHALL accept the command and stay in IDLE, producing no output.
REQ-014 On IDLE with cmd_valid and cmd_len>0, the block SHALL load the address counter with cmd_addr and the remaining count with cmd_len, and go to ISSUE.
REQ-015 The credit condition SHALL be: occ + v1 + v2 <= 3, where occ is the FIFO occupancy (all registered values).
REQ-016 ram_rd_en SHALL be 1 when the credit condition holds and either (state=ISSUE) or (state=DRAIN and (v1 or v2)); otherwise ram_rd_en SHALL be 0.
REQ-017 On an ISSUE advance, ram_rd_addr SHALL equal the address counter, v1 SHALL be set, and l1 SHALL equal (remaining=1).
REQ-018 On an ISSUE advance, the counter SHALL increment modulo DEPTH (wrap DEPTH-1 -> 0) and remaining SHALL decrement.
REQ-019 The advance that issues remaining=1 SHALL move the state to DRAIN.
REQ-020 On a DRAIN advance, v1 SHALL be cleared and ram_rd_addr SHALL be don't-care.
REQ-021 On any advance with v2=1, the block SHALL push {l2, ram_rd_data} into the FIFO before the stage shift.
REQ-022 FIFO behaviour:
- out_valid = (occ != 0); out_data and out_last come from the FIFO head.
- A pop occurs on out_valid && out_ready.
- A simultaneous push and pop leaves occ unchanged.
REQ-023 The FIFO SHALL never overflow; occupancy above 4 is an error.
REQ-024 DRAIN SHALL go to IDLE in the cycle the pop of the out_last word occurs.
REQ-025 Latency: a command accepted in cycle 0 SHALL give the first out_valid in cycle 4.
REQ-026 Throughput: with out_ready held at 1, the block SHALL sustain 1 word per cycle after the first word.
REQ-027 Backpressure: with out_ready=0, ram_rd_en SHALL drop once the credit is exhausted, and no word SHALL be lost or duplicated.
REQ-028 Output order SHALL equal address order: cmd_addr, cmd_addr+1, ... mod DEPTH; cmd_len > DEPTH re-reads wrapped addresses.

Reset
REQ-029 While rstn=0, the block SHALL asynchronously hold: state IDLE, v1=v2=l1=l2=0, occ=0, counters 0, cmd_ready=1, out_valid=0, out_last=0, ram_rd_en=0, ram_rd_addr=0, busy=0.
REQ-030 Reset asserted mid-command SHALL discard all in-flight and buffered words.
REQ-031 After reset release, stale RAM stage contents SHALL never appear at the output.

Verification
REQ-032 Scenario "basic read": RAM preloaded mem[i]=i+0x100; cmd addr=5 len=3, out_ready=1 -> 0x105, 0x106, 0x107, with out_last on 0x107, first out_valid 4 cycles after acceptance, then busy=0.
REQ-033 Scenario "wrap": ADDR_WIDTH=10, cmd addr=1022 len=4 -> words from addresses 1022, 1023, 0, 1.
REQ-034 Scenario "backpressure": len=16, out_ready toggled by random 30% duty -> all 16 words in order, occ never >4, ram_rd_en=0 whenever occ+v1+v2>3.
REQ-035 Scenario "zero length": cmd len=0 -> accepted in one cycle, no out_valid, busy stays 0, next command (addr=0 len=1) is served normally.
REQ-036 Scenario "reset mid-stream": rstn pulsed low at word 5 of len=10 -> out_valid=0 immediately, cmd_ready=1; a new cmd addr=0 len=2 yields exactly mem[0], mem[1].
